sha2_stream_core: RTL and testbench

- Next-generation SHA-2 compression engine.
- Accepts message blocks as a 32-bit word stream with valid/ready handshake.
- Supports SHA-256 and SHA-224 per message and chains multi-block messages internally.
- Configurable rounds-per-cycle unrolling.
- Sits between the host padding/word-feed logic and the digest consumer; padding is done upstream.

---
 rtl/sha2_stream_core.sv | 219 +++++++++++++++++++++
 tb/tb_sha2_stream_core.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sha2_stream_core.sv
// SHA-256/SHA-224 compression core fed by a 32-bit word stream; chains multi-block
// messages internally and performs UNROLL rounds per clock.
module sha2_stream_core #(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode_224,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [255:0] digest,
  output logic         busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
    $error("sha2_stream_core: UNROLL must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {StLoad, StComp, StFinal, StOut} state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] Iv256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] Iv224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [5:0]          rnd_q, rnd_d;
  logic                msg_start_q, msg_start_d;
  logic                mode_q, mode_d;
  logic                last_q, last_d;
  logic [15:0][31:0]   w_q, w_d;
  // work_q[0..7] = a..h, h_q[0..7] = chaining h0..h7
  logic [7:0][31:0]    work_q, work_d;
  logic [7:0][31:0]    h_q, h_d;
  logic [255:0]        digest_q, digest_d;
  logic                in_ready_q, in_ready_d;
  logic                digest_valid_q, digest_valid_d;
  logic                busy_q, busy_d;

  logic                xfer;
  logic [15:0][31:0]   w_tmp;
  logic [7:0][31:0]    work_v;
  logic [5:0]          t;
  logic [3:0]          ti;
  logic [31:0]         wt, t1, t2;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rnd_d       = rnd_q;
    msg_start_d = msg_start_q;
    mode_d      = mode_q;
    last_d      = last_q;
    w_d         = w_q;
    work_d      = work_q;
    h_d         = h_q;
    digest_d    = digest_q;
    w_tmp       = w_q;
    work_v      = work_q;
    t           = '0;
    ti          = '0;
    wt          = '0;
    t1          = '0;
    t2          = '0;
    xfer        = in_valid && in_ready_q;

    unique case (state_q)
      StLoad: begin
        if (xfer) begin
          w_d[cnt_q] = in_data;
          cnt_d      = cnt_q + 4'd1;
          if (msg_start_q) begin
            mode_d      = mode_224;
            msg_start_d = 1'b0;
            for (int i = 0; i < 8; i++) begin
              h_d[3'(i)] = mode_224 ? Iv224[3'(i)] : Iv256[3'(i)];
            end
          end
          if (cnt_q == 4'd15) begin
            last_d  = in_last;
            work_d  = h_d;
            rnd_d   = '0;
            state_d = StComp;
          end
        end
      end
      StComp: begin
        for (int u = 0; u < int'(UNROLL); u++) begin
          t  = rnd_q + 6'(u);
          ti = t[3:0];
          if (t < 6'd16) begin
            wt = w_tmp[ti];
          end else begin
            // Slot ti still holds w[t-16]; it is replaced by w[t]
            wt = small_sigma1(w_tmp[ti - 4'd2]) + w_tmp[ti - 4'd7]
               + small_sigma0(w_tmp[ti - 4'd15]) + w_tmp[ti];
            w_tmp[ti] = wt;
          end
          t1 = work_v[7] + big_sigma1(work_v[4])
             + ((work_v[4] & work_v[5]) ^ (~work_v[4] & work_v[6])) + K[t] + wt;
          t2 = big_sigma0(work_v[0])
             + ((work_v[0] & work_v[1]) ^ (work_v[0] & work_v[2]) ^ (work_v[1] & work_v[2]));
          work_v    = {work_v[6:0], t1 + t2};
          work_v[4] = work_v[4] + t1;
        end
        w_d    = w_tmp;
        work_d = work_v;
        rnd_d  = rnd_q + 6'(UNROLL);
        if (rnd_q == 6'(64 - UNROLL)) begin
          state_d = StFinal;
        end
      end
      StFinal: begin
        for (int i = 0; i < 8; i++) begin
          h_d[3'(i)] = h_q[3'(i)] + work_q[3'(i)];
        end
        digest_d = {h_d[0], h_d[1], h_d[2], h_d[3], h_d[4], h_d[5], h_d[6],
                    mode_q ? 32'h0 : h_d[7]};
        cnt_d    = '0;
        state_d  = last_q ? StOut : StLoad;
      end
      StOut: begin
        if (digest_ready) begin
          state_d     = StLoad;
          cnt_d       = '0;
          msg_start_d = 1'b1;
        end
      end
      default: state_d = StLoad;
    endcase

    in_ready_d     = (state_d == StLoad);
    digest_valid_d = (state_d == StOut);
    busy_d         = !((state_d == StLoad) && (cnt_d == 4'd0) && msg_start_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StLoad;
      cnt_q          <= '0;
      rnd_q          <= '0;
      msg_start_q    <= 1'b1;
      mode_q         <= 1'b0;
      last_q         <= 1'b0;
      w_q            <= '0;
      work_q         <= '0;
      h_q            <= '0;
      digest_q       <= '0;
      in_ready_q     <= 1'b1;
      digest_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rnd_q          <= rnd_d;
      msg_start_q    <= msg_start_d;
      mode_q         <= mode_d;
      last_q         <= last_d;
      w_q            <= w_d;
      work_q         <= work_d;
      h_q            <= h_d;
      digest_q       <= digest_d;
      in_ready_q     <= in_ready_d;
      digest_valid_q <= digest_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign digest_valid = digest_valid_q;
  assign digest       = digest_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sha2_stream_core.sv
// Directed bench for sha2_stream_core: one instance per UNROLL value (1, 2, 4),
// driven one at a time through shared stimulus with known FIPS 180-4 digests.
module tb_sha2_stream_core;

  localparam logic [511:0] AbcBlk = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] TwoBlk1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TwoBlk2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] ExpAbc256 =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ExpAbc224 =
    {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
  localparam logic [255:0] ExpTwo256 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic        clk = 1'b0;
  logic        rst_n, mode_224, in_valid, in_last, digest_ready;
  logic [31:0] in_data;
  int          sel, cyc, n_edge, n_vec, n_err;

  logic         in_valid_v [3];
  logic         ready_v    [3];
  logic         dr_v       [3];
  logic         dvalid_v   [3];
  logic         busy_v     [3];
  logic [255:0] digest_v   [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    assign in_valid_v[k] = in_valid && (sel == k);
    assign dr_v[k]       = digest_ready && (sel == k);
    sha2_stream_core #(.UNROLL(1 << k)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mode_224     (mode_224),
      .in_valid     (in_valid_v[k]),
      .in_ready     (ready_v[k]),
      .in_data      (in_data),
      .in_last      (in_last),
      .digest_valid (dvalid_v[k]),
      .digest_ready (dr_v[k]),
      .digest       (digest_v[k]),
      .busy         (busy_v[k])
    );
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after word 15 transfers.
  task automatic send_block(input logic [511:0] blk, input logic last, input logic mode,
                            input int gap_max, output int wait0);
    int g, guard;
    wait0 = 0;
    for (int i = 0; i < 16; i++) begin
      if (gap_max > 0) begin
        g = int'($urandom_range(gap_max, 0));
        in_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
      in_data  = blk[511 - 32*i -: 32];
      in_last  = (i == 15) ? last : ~last;
      mode_224 = (i == 0) ? mode : ~mode;
      in_valid = 1'b1;
      guard = 0;
      while (!ready_v[sel] && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (i == 0) wait0 = guard;
      if (guard >= 300) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: in_ready stuck low at word %0d, required high", i);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_edge   = cyc;
  endtask

  task automatic wait_digest(input string tag, input logic [255:0] exp, input int lat_exp,
                             input int hold);
    int guard;
    logic [255:0] d0;
    logic stable;
    guard = 0;
    while (!dvalid_v[sel] && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_lat"}, 256'(cyc - n_edge), 256'(lat_exp));
    check_eq({tag, "_digest"}, digest_v[sel], exp);
    if (hold > 0) begin
      d0 = digest_v[sel];
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!dvalid_v[sel] || ready_v[sel] || digest_v[sel] !== d0) stable = 1'b0;
      end
      check_eq({tag, "_hold"}, 256'(stable), 256'(1));
    end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    check_eq({tag, "_done"}, 256'({dvalid_v[sel], ready_v[sel], busy_v[sel]}), 256'(3'b010));
  endtask

  initial begin
    int w, lat, guard;
    rst_n = 1'b0; mode_224 = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; digest_ready = 1'b0; sel = 0; n_vec = 0; n_err = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rst_flags_u%0d", 1 << k),
               256'({ready_v[k], dvalid_v[k], busy_v[k]}), 256'(3'b100));
      check_eq($sformatf("rst_digest_u%0d", 1 << k), digest_v[k], 256'(0));
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      sel = k;
      lat = 64 / (1 << k) + 1;
      send_block(AbcBlk, 1'b1, 1'b0, 0, w);
      wait_digest($sformatf("abc256_u%0d", 1 << k), ExpAbc256, lat, 0);
      send_block(AbcBlk, 1'b1, 1'b1, 0, w);
      wait_digest($sformatf("abc224_u%0d", 1 << k), ExpAbc224, lat, 0);
      send_block(TwoBlk1, 1'b0, 1'b0, 0, w);
      check_eq($sformatf("two_busy_u%0d", 1 << k), 256'(busy_v[k]), 256'(1));
      send_block(TwoBlk2, 1'b1, 1'b0, 0, w);
      check_eq($sformatf("two_ready_gap_u%0d", 1 << k), 256'(w), 256'(lat));
      wait_digest($sformatf("two256_u%0d", 1 << k), ExpTwo256, lat, 0);
    end

    // Backpressure on both sides, then an immediate second message.
    sel = 0;
    send_block(AbcBlk, 1'b1, 1'b0, 3, w);
    wait_digest("gapped_abc", ExpAbc256, 65, 10);
    send_block(AbcBlk, 1'b1, 1'b0, 0, w);
    wait_digest("b2b_abc", ExpAbc256, 65, 0);

    // Park a digest on UNROLL=4, then reset mid-compression on UNROLL=2.
    sel = 2;
    send_block(AbcBlk, 1'b1, 1'b0, 0, w);
    guard = 0;
    while (!dvalid_v[2] && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check_eq("park_valid", 256'(dvalid_v[2]), 256'(1));
    sel = 1;
    send_block(TwoBlk1, 1'b0, 1'b0, 0, w);
    repeat (5) @(negedge clk);
    check_eq("midcomp_flags", 256'({ready_v[1], busy_v[1]}), 256'(2'b01));
    rst_n = 1'b0;
    #1;
    check_eq("rst_drop_valid", 256'(dvalid_v[2]), 256'(0));
    check_eq("rst_drop_digest", digest_v[2], 256'(0));
    check_eq("rst_midcomp_flags", 256'({ready_v[1], busy_v[1]}), 256'(2'b10));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_block(AbcBlk, 1'b1, 1'b0, 0, w);
    wait_digest("post_rst_abc", ExpAbc256, 33, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
